l1_line_responder: RTL

- Responder end of the L1 cacheline (pmem) interface. It accepts 256-bit line read and write requests from an L1 cache datapath and control pair.
- It serves each request as a 4-beat, 64-bit burst on the downstream physical-memory port, then returns a one-cycle pmem_resp.
- It sits between the L1D/L1I caches (or the L1 arbiter) and physical memory or the L2 port.

---
 rtl/l1_line_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/l1_line_responder.sv
// l1_line_responder: serves 256-bit L1 line requests as BEATS-beat pmem bursts.
// Optional last-line buffer enabled by defining RESP_LINE_BUF_EN.
module l1_line_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [255:0]          pmem_wdata,
    output logic [255:0]          pmem_rdata,
    output logic                  pmem_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam int LINE_W = 256;
    localparam int BEATS  = LINE_W / BEAT_WIDTH;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH-5){1'b1}}, 5'b0};

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE,
        GAP
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LINE_W-1:0]     line_q;
    logic [LINE_W-1:0]     rdata_q;
    logic [LINE_W-1:0]     rdata_d;
    logic                  rd_q;
    logic                  wr_q;
    logic                  resp_q;
    logic                  last_beat;
    logic                  hit;
    logic [LINE_W-1:0]     hit_line;

    assign addr_d    = pmem_address & ALIGN_MASK;
    assign last_beat = (cnt_q == LAST_BEAT);

    // Read line with the incoming beat merged into its slot
    always_comb begin
        rdata_d = rdata_q;
        rdata_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
    end

    assign burst_wdata   = line_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH];
    assign burst_address = addr_q;
    assign burst_read    = rd_q;
    assign burst_write   = wr_q;
    assign pmem_resp     = resp_q;
    assign pmem_rdata    = rdata_q;

`ifdef RESP_LINE_BUF_EN
    logic                  buf_vld_q;
    logic [ADDR_WIDTH-1:0] buf_addr_q;
    logic [LINE_W-1:0]     buf_line_q;

    assign hit      = buf_vld_q && (buf_addr_q == addr_d);
    assign hit_line = buf_line_q;

    // Buffer tracks the most recently written or fully read line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_line_q <= '0;
        end else if (state_q == IDLE && pmem_write) begin
            buf_vld_q  <= 1'b1;
            buf_addr_q <= addr_d;
            buf_line_q <= pmem_wdata;
        end else if (state_q == RD && burst_resp && last_beat) begin
            buf_vld_q  <= 1'b1;
            buf_addr_q <= addr_q;
            buf_line_q <= rdata_d;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_line = '0;
`endif

    // Request FSM; write wins when both requests are high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pmem_write) begin
                        addr_q  <= addr_d;
                        line_q  <= pmem_wdata;
                        wr_q    <= 1'b1;
                        state_q <= WR;
                    end else if (pmem_read) begin
                        addr_q <= addr_d;
                        if (hit) begin
                            rdata_q <= hit_line;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (burst_resp) begin
                        rdata_q <= rdata_d;
                        if (last_beat) begin
                            cnt_q   <= '0;
                            rd_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                WR: begin
                    if (burst_resp) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            wr_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
